// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported memory between the instruction-fetch stage (IF)
// and the data-memory stage (MEM). One access is outstanding at a time. It
// walks IDLE -> ISSUE -> WAIT -> DONE -> IDLE. Data requests win ties. A
// streak counter hands the port to a waiting fetch after MAX_DSTREAK
// consecutive data grants.
//
// Every output except the stalls comes from a register that is loaded from
// the current state. Each visible effect therefore appears one cycle after
// the state that produces it:
//   - mem_en is visible in the first WAIT cycle.
//   - mem_rdata is valid while the FSM is in DONE.
//   - The ack pulse is visible in the IDLE cycle that follows DONE.
// A request seen in IDLE cycle t is acked in cycle t+MEM_LAT+3. The port can
// issue at most one access every MEM_LAT+3 cycles.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   if_req/if_addr     fetch request, held until if_ack
//   if_ack/if_rdata    one-cycle fetch completion pulse with fetched word
//   d_req/d_we/d_addr/d_wdata  data request (we=1 write), held until d_ack
//   d_ack/d_rdata      one-cycle data completion pulse, load data on reads
//   mem_en/mem_we/mem_addr/mem_wdata  memory strobe (one cycle per access)
//   mem_rdata          memory read data, valid MEM_LAT cycles after mem_en
//   stall_if/stall_mem combinational pipeline freezes: req & ~ack
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LAT     = 2,
   parameter int MAX_DSTREAK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);
   localparam int STK_W = $clog2(MAX_DSTREAK + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state;
   state_t             next_state;
   logic               grant_d;
   logic               grant_i;

   logic [CNT_W-1:0]   wait_cnt;
   logic [STK_W-1:0]   streak;

   // Attributes of the access in flight, latched at grant time.
   logic               own_d;
   logic               lat_we;
   logic [ADDR_W-1:0]  lat_addr;
   logic [DATA_W-1:0]  lat_wdata;

   // -------------------------------------------------------------------------
   // Next-state and grant decision
   // -------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave a value unassigned and infer a latch.
   always_comb begin
      next_state = state;
      grant_d    = 1'b0;
      grant_i    = 1'b0;
      case (state)
         IDLE: begin
            // Data wins unless a waiting fetch has already seen
            // MAX_DSTREAK data grants in a row.
            if (d_req && (!if_req || streak != STK_W'(MAX_DSTREAK))) begin
               grant_d = 1'b1;
            end else if (if_req) begin
               grant_i = 1'b1;
            end
            if (grant_d || grant_i) begin
               next_state = ISSUE;
            end
         end
         ISSUE:   next_state = WAIT;
         WAIT:    if (wait_cnt == CNT_W'(1)) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // State, bookkeeping and registered outputs
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only. Every
   // register then samples pre-edge values and the order of statements
   // inside the block does not matter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         streak    <= '0;
         own_d     <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_ack    <= 1'b0;
         d_ack     <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         state <= next_state;

         // Grant: capture the winner's request.
         if (grant_d) begin
            own_d     <= 1'b1;
            lat_we    <= d_we;
            lat_addr  <= d_addr;
            lat_wdata <= d_wdata;
            // Data grants count against a fetch only while it is waiting.
            if (!if_req) begin
               streak <= '0;
            end else if (streak != STK_W'(MAX_DSTREAK)) begin
               streak <= streak + STK_W'(1);
            end
         end else if (grant_i) begin
            own_d     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= if_addr;
            lat_wdata <= '0;
            streak    <= '0;
         end else if (state == IDLE) begin
            streak <= '0;
         end

         // WAIT lasts MEM_LAT cycles and counts MEM_LAT down to 1.
         if (state == ISSUE) begin
            wait_cnt <= CNT_W'(MEM_LAT);
         end else if (state == WAIT) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
         end

         // The memory strobe is registered from ISSUE. It is visible in the
         // first WAIT cycle, and write enable never outlives it.
         mem_en <= (state == ISSUE);
         mem_we <= (state == ISSUE) && lat_we;
         if (state == ISSUE) begin
            mem_addr  <= lat_addr;
            mem_wdata <= lat_wdata;
         end

         // Because the strobe lags by one cycle, the read word is on
         // mem_rdata while the FSM sits in DONE. It is captured together with
         // the ack, so the ack and its data appear in the same cycle.
         if_ack <= (state == DONE) && !own_d;
         d_ack  <= (state == DONE) && own_d;
         if (state == DONE && !lat_we) begin
            if (own_d) begin
               d_rdata <= mem_rdata;
            end else begin
               if_rdata <= mem_rdata;
            end
         end
      end
   end

   assign stall_if  = if_req & ~if_ack;
   assign stall_mem = d_req & ~d_ack;

endmodule
